sparse_job_master: RTL and testbench

SPARSE_JOB_MASTER -- requirements
Module: sparse_job_master

---
 rtl/sparse_job_master_if.sv | 39 +++
 rtl/sparse_job_master.sv | 285 ++++++++++++++++++++++++++++
 tb/tb_sparse_job_master.sv | 274 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/sparse_job_master_if.sv
// -----------------------------------------------------------------------------
// sparse_job_master_if
// AXI-Lite bundle between the sparse job master and the sparse core register
// map. It carries no clock or reset; those stay plain ports on the modules.
//   master modport : drives aw*/w*/ar* valids and payloads, bready, rready
//   slave modport  : drives aw/w/ar readies, b* and r* response channels
// -----------------------------------------------------------------------------
interface sparse_job_master_if #(
    parameter int AXI_DATA_WIDTH = 32,
    parameter int AXI_ADDR_WIDTH = 6
);
    logic [AXI_ADDR_WIDTH-1:0] awaddr;
    logic                      awvalid;
    logic                      awready;
    logic [AXI_DATA_WIDTH-1:0] wdata;
    logic [3:0]                wstrb;
    logic                      wvalid;
    logic                      wready;
    logic [1:0]                bresp;
    logic                      bvalid;
    logic                      bready;
    logic [AXI_ADDR_WIDTH-1:0] araddr;
    logic                      arvalid;
    logic                      arready;
    logic [AXI_DATA_WIDTH-1:0] rdata;
    logic [1:0]                rresp;
    logic                      rvalid;
    logic                      rready;

    modport master (
        output awaddr, awvalid, wdata, wstrb, wvalid, bready, araddr, arvalid, rready,
        input  awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
    );

    modport slave (
        input  awaddr, awvalid, wdata, wstrb, wvalid, bready, araddr, arvalid, rready,
        output awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
    );
endinterface

// File: rtl/sparse_job_master.sv
// -----------------------------------------------------------------------------
// sparse_job_master
// Runs one job on the downstream sparse core: writes the four vector lanes to
// 0x04..0x10, writes 1 to the start register at 0x00, idles WAIT_CYCLES+1
// cycles, then reads the four result rows from 0x14..0x20. Exactly one AXI
// transaction is ever outstanding. Response errors are accumulated into
// res_err but never abort the sequence.
// Ports:
//   aclk, aresetn         clock, synchronous active-low reset
//   job_valid/job_ready   job handshake, job_vec = 4 packed lanes (lane 0 LSB)
//   res_valid/res_ready   result handshake, res_vec = 4 packed rows, res_err
//   busy                  high whenever the sequencer is not idle
//   m_axi                 AXI-Lite master (sparse_job_master_if.master)
// All outputs come straight from registers.
// -----------------------------------------------------------------------------
module sparse_job_master #(
    parameter int AXI_DATA_WIDTH = 32,
    parameter int AXI_ADDR_WIDTH = 6,
    parameter int WAIT_CYCLES    = 8
) (
    input  logic                        aclk,
    input  logic                        aresetn,
    input  logic                        job_valid,
    output logic                        job_ready,
    input  logic [4*AXI_DATA_WIDTH-1:0] job_vec,
    output logic                        res_valid,
    input  logic                        res_ready,
    output logic [4*AXI_DATA_WIDTH-1:0] res_vec,
    output logic                        res_err,
    output logic                        busy,
    sparse_job_master_if.master         m_axi
);
    localparam int DW = AXI_DATA_WIDTH;
    localparam int AW = AXI_ADDR_WIDTH;
    localparam int VW = 4 * AXI_DATA_WIDTH;

    typedef enum logic [2:0] {
        S_IDLE, S_WR, S_WR_RESP, S_WAIT, S_RD, S_RD_RESP, S_OUT
    } state_t;

    // Write index 0..3 targets the lane registers, index 4 the start register.
    function automatic logic [AW-1:0] wr_addr_f(input logic [2:0] k);
        logic [7:0] a;
        a = (k == 3'd4) ? 8'h00 : (8'h04 + {3'b000, k, 2'b00});
        return AW'(a);
    endfunction

    // Result rows live at 0x14 + 4*k.
    function automatic logic [AW-1:0] rd_addr_f(input logic [2:0] k);
        logic [7:0] a;
        a = 8'h14 + {3'b000, k, 2'b00};
        return AW'(a);
    endfunction

    state_t          state_q, state_d;
    logic [2:0]      k_q, k_d;
    logic [7:0]      cnt_q, cnt_d;
    logic [VW-1:0]   vec_q, vec_d;
    logic [VW-1:0]   res_vec_q, res_vec_d;
    logic            res_err_q, res_err_d;
    logic            res_valid_q, res_valid_d;
    logic            job_ready_q, job_ready_d;
    logic            busy_q, busy_d;
    logic            awvalid_q, awvalid_d;
    logic            wvalid_q, wvalid_d;
    logic            aw_done_q, aw_done_d;
    logic            w_done_q, w_done_d;
    logic            wr_started_q, wr_started_d;
    logic            bready_q, bready_d;
    logic            arvalid_q, arvalid_d;
    logic            rready_q, rready_d;
    logic [AW-1:0]   awaddr_q, awaddr_d;
    logic [DW-1:0]   wdata_q, wdata_d;
    logic [AW-1:0]   araddr_q, araddr_d;

    logic aw_hs_s, w_hs_s, aw_ok_s, w_ok_s;

    // Next-state and next-output logic for the job sequencer.
    always_comb begin
        state_d      = state_q;
        k_d          = k_q;
        cnt_d        = cnt_q;
        vec_d        = vec_q;
        res_vec_d    = res_vec_q;
        res_err_d    = res_err_q;
        res_valid_d  = res_valid_q;
        awvalid_d    = awvalid_q;
        wvalid_d     = wvalid_q;
        aw_done_d    = aw_done_q;
        w_done_d     = w_done_q;
        wr_started_d = wr_started_q;
        bready_d     = bready_q;
        arvalid_d    = arvalid_q;
        rready_d     = rready_q;
        awaddr_d     = awaddr_q;
        wdata_d      = wdata_q;
        araddr_d     = araddr_q;

        aw_hs_s = awvalid_q & m_axi.awready;
        w_hs_s  = wvalid_q & m_axi.wready;
        // A channel counts as done if it handshook earlier or does so now.
        aw_ok_s = aw_done_q | aw_hs_s;
        w_ok_s  = w_done_q | w_hs_s;

        case (state_q)
            S_IDLE: begin
                if (job_valid && job_ready_q) begin
                    vec_d        = job_vec;
                    res_err_d    = 1'b0;
                    k_d          = 3'd0;
                    wr_started_d = 1'b0;
                    state_d      = S_WR;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_WR: begin
                if (!wr_started_q) begin
                    // First WR cycle only launches both channels.
                    wr_started_d = 1'b1;
                    awvalid_d    = 1'b1;
                    wvalid_d     = 1'b1;
                    aw_done_d    = 1'b0;
                    w_done_d     = 1'b0;
                    awaddr_d     = wr_addr_f(k_q);
                    if (k_q == 3'd4) begin
                        wdata_d = {{(DW-1){1'b0}}, 1'b1};
                    end else begin
                        wdata_d = vec_q[k_q[1:0]*DW +: DW];
                    end
                end else begin
                    if (aw_hs_s) begin
                        awvalid_d = 1'b0;
                        aw_done_d = 1'b1;
                    end else begin
                        awvalid_d = awvalid_q;
                    end
                    if (w_hs_s) begin
                        wvalid_d = 1'b0;
                        w_done_d = 1'b1;
                    end else begin
                        wvalid_d = wvalid_q;
                    end
                    if (aw_ok_s && w_ok_s) begin
                        bready_d = 1'b1;
                        state_d  = S_WR_RESP;
                    end else begin
                        state_d = S_WR;
                    end
                end
            end
            S_WR_RESP: begin
                if (m_axi.bvalid && bready_q) begin
                    bready_d  = 1'b0;
                    res_err_d = res_err_q | (m_axi.bresp != 2'b00);
                    if (k_q == 3'd4) begin
                        cnt_d   = 8'(WAIT_CYCLES);
                        k_d     = 3'd0;
                        state_d = S_WAIT;
                    end else begin
                        k_d          = k_q + 3'd1;
                        wr_started_d = 1'b0;
                        state_d      = S_WR;
                    end
                end else begin
                    state_d = S_WR_RESP;
                end
            end
            S_WAIT: begin
                // Counter runs WAIT_CYCLES down to zero inclusive.
                if (cnt_q == 8'd0) begin
                    k_d       = 3'd0;
                    arvalid_d = 1'b1;
                    araddr_d  = rd_addr_f(3'd0);
                    state_d   = S_RD;
                end else begin
                    cnt_d = cnt_q - 8'd1;
                end
            end
            S_RD: begin
                if (arvalid_q && m_axi.arready) begin
                    arvalid_d = 1'b0;
                    rready_d  = 1'b1;
                    state_d   = S_RD_RESP;
                end else begin
                    state_d = S_RD;
                end
            end
            S_RD_RESP: begin
                if (m_axi.rvalid && rready_q) begin
                    rready_d                      = 1'b0;
                    res_vec_d[k_q[1:0]*DW +: DW]  = m_axi.rdata;
                    res_err_d                     = res_err_q | (m_axi.rresp != 2'b00);
                    if (k_q == 3'd3) begin
                        res_valid_d = 1'b1;
                        state_d     = S_OUT;
                    end else begin
                        k_d       = k_q + 3'd1;
                        arvalid_d = 1'b1;
                        araddr_d  = rd_addr_f(k_q + 3'd1);
                        state_d   = S_RD;
                    end
                end else begin
                    state_d = S_RD_RESP;
                end
            end
            S_OUT: begin
                if (res_valid_q && res_ready) begin
                    res_valid_d = 1'b0;
                    state_d     = S_IDLE;
                end else begin
                    state_d = S_OUT;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        job_ready_d = (state_d == S_IDLE);
        busy_d      = (state_d != S_IDLE);
    end

    // State and output registers with synchronous active-low reset.
    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            state_q      <= S_IDLE;
            k_q          <= 3'd0;
            cnt_q        <= 8'd0;
            vec_q        <= {VW{1'b0}};
            res_vec_q    <= {VW{1'b0}};
            res_err_q    <= 1'b0;
            res_valid_q  <= 1'b0;
            job_ready_q  <= 1'b1;
            busy_q       <= 1'b0;
            awvalid_q    <= 1'b0;
            wvalid_q     <= 1'b0;
            aw_done_q    <= 1'b0;
            w_done_q     <= 1'b0;
            wr_started_q <= 1'b0;
            bready_q     <= 1'b0;
            arvalid_q    <= 1'b0;
            rready_q     <= 1'b0;
            awaddr_q     <= {AW{1'b0}};
            wdata_q      <= {DW{1'b0}};
            araddr_q     <= {AW{1'b0}};
        end else begin
            state_q      <= state_d;
            k_q          <= k_d;
            cnt_q        <= cnt_d;
            vec_q        <= vec_d;
            res_vec_q    <= res_vec_d;
            res_err_q    <= res_err_d;
            res_valid_q  <= res_valid_d;
            job_ready_q  <= job_ready_d;
            busy_q       <= busy_d;
            awvalid_q    <= awvalid_d;
            wvalid_q     <= wvalid_d;
            aw_done_q    <= aw_done_d;
            w_done_q     <= w_done_d;
            wr_started_q <= wr_started_d;
            bready_q     <= bready_d;
            arvalid_q    <= arvalid_d;
            rready_q     <= rready_d;
            awaddr_q     <= awaddr_d;
            wdata_q      <= wdata_d;
            araddr_q     <= araddr_d;
        end
    end

    assign job_ready     = job_ready_q;
    assign busy          = busy_q;
    assign res_valid     = res_valid_q;
    assign res_vec       = res_vec_q;
    assign res_err       = res_err_q;
    assign m_axi.awaddr  = awaddr_q;
    assign m_axi.awvalid = awvalid_q;
    assign m_axi.wdata   = wdata_q;
    assign m_axi.wstrb   = 4'hF;
    assign m_axi.wvalid  = wvalid_q;
    assign m_axi.bready  = bready_q;
    assign m_axi.araddr  = araddr_q;
    assign m_axi.arvalid = arvalid_q;
    assign m_axi.rready  = rready_q;
endmodule

// File: tb/tb_sparse_job_master.sv
// -----------------------------------------------------------------------------
// tb_sparse_job_master
// Directed sequence of jobs with randomized vectors, read data and slave
// stalls. A behavioural AXI-Lite slave logs every transaction; expectations
// come from the job-level rules (address map, lane order, error OR, latency).
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_sparse_job_master;
    localparam int DW = 32;
    localparam int AW = 6;
    localparam int VW = 4 * DW;
    localparam int WC = 8;

    logic          aclk = 1'b0;
    logic          aresetn = 1'b0;
    logic          job_valid = 1'b0;
    logic          job_ready;
    logic [VW-1:0] job_vec = '0;
    logic          res_valid;
    logic          res_ready = 1'b0;
    logic [VW-1:0] res_vec;
    logic          res_err;
    logic          busy;

    always #5 aclk = ~aclk;

    sparse_job_master_if #(.AXI_DATA_WIDTH(DW), .AXI_ADDR_WIDTH(AW)) axi ();

    sparse_job_master #(
        .AXI_DATA_WIDTH(DW), .AXI_ADDR_WIDTH(AW), .WAIT_CYCLES(WC)
    ) dut (
        .aclk(aclk), .aresetn(aresetn),
        .job_valid(job_valid), .job_ready(job_ready), .job_vec(job_vec),
        .res_valid(res_valid), .res_ready(res_ready), .res_vec(res_vec),
        .res_err(res_err), .busy(busy), .m_axi(axi)
    );

    // ---------------- behavioural slave ----------------
    int aw_delay = 0, w_delay = 0, b_err_at = -1, r_err_at = -1;
    logic [DW-1:0] rmem [4];
    int  aw_cnt, w_cnt, wr_idx, rd_idx, viol, traffic = 0;
    bit  got_aw, got_w, wr_pend, aw_wait_p, w_wait_p, ar_wait_p;
    logic          bvalid_r, rvalid_r;
    logic [1:0]    bresp_r, rresp_r;
    logic [DW-1:0] rdata_r;
    logic [AW-1:0] wr_addr_log[$];
    logic [DW-1:0] wr_data_log[$];
    logic [AW-1:0] rd_addr_log[$];
    int            aw_len_log[$];
    int            w_len_log[$];
    logic aw_hs, w_hs, ar_hs;

    assign axi.awready = axi.awvalid && (aw_cnt >= aw_delay) && !got_aw;
    assign axi.wready  = axi.wvalid && (w_cnt >= w_delay) && !got_w;
    assign axi.arready = axi.arvalid;
    assign axi.bvalid  = bvalid_r;
    assign axi.bresp   = bresp_r;
    assign axi.rvalid  = rvalid_r;
    assign axi.rdata   = rdata_r;
    assign axi.rresp   = rresp_r;
    assign aw_hs = axi.awvalid && axi.awready;
    assign w_hs  = axi.wvalid && axi.wready;
    assign ar_hs = axi.arvalid && axi.arready;

    always @(posedge aclk) begin
        if (!aresetn) begin
            aw_cnt <= 0; w_cnt <= 0; wr_idx <= 0; rd_idx <= 0; viol <= 0;
            got_aw <= 1'b0; got_w <= 1'b0; wr_pend <= 1'b0;
            aw_wait_p <= 1'b0; w_wait_p <= 1'b0; ar_wait_p <= 1'b0;
            bvalid_r <= 1'b0; rvalid_r <= 1'b0; bresp_r <= 2'b00; rresp_r <= 2'b00;
            rdata_r <= '0;
            wr_addr_log.delete(); wr_data_log.delete(); rd_addr_log.delete();
            aw_len_log.delete(); w_len_log.delete();
        end else begin
            if (axi.awvalid || axi.wvalid || axi.arvalid) traffic <= traffic + 1;
            // protocol monitor: no dropped valids, one outstanding, bready late
            if ((aw_wait_p && !axi.awvalid) || (w_wait_p && !axi.wvalid) ||
                (ar_wait_p && !axi.arvalid)) viol <= viol + 1;
            else if ((axi.awvalid || axi.wvalid || axi.arvalid) && (wr_pend || rvalid_r))
                viol <= viol + 1;
            else if (axi.bready && !wr_pend) viol <= viol + 1;
            else if (axi.wvalid && axi.wstrb !== 4'hF) viol <= viol + 1;
            aw_wait_p <= axi.awvalid && !axi.awready;
            w_wait_p  <= axi.wvalid && !axi.wready;
            ar_wait_p <= axi.arvalid && !axi.arready;
            if (aw_hs) begin
                wr_addr_log.push_back(axi.awaddr); aw_len_log.push_back(aw_cnt + 1);
                aw_cnt <= 0; got_aw <= 1'b1;
            end else if (axi.awvalid) aw_cnt <= aw_cnt + 1;
            if (w_hs) begin
                wr_data_log.push_back(axi.wdata); w_len_log.push_back(w_cnt + 1);
                w_cnt <= 0; got_w <= 1'b1;
            end else if (axi.wvalid) w_cnt <= w_cnt + 1;
            if ((got_aw || aw_hs) && (got_w || w_hs) && !wr_pend) begin
                got_aw <= 1'b0; got_w <= 1'b0; wr_pend <= 1'b1; bvalid_r <= 1'b1;
                bresp_r <= ((wr_idx % 5) == b_err_at) ? 2'b10 : 2'b00;
            end
            if (bvalid_r && axi.bready) begin
                bvalid_r <= 1'b0; wr_pend <= 1'b0; wr_idx <= wr_idx + 1;
            end
            if (ar_hs) begin
                rd_addr_log.push_back(axi.araddr);
                rvalid_r <= 1'b1;
                rdata_r  <= rmem[rd_idx % 4];
                rresp_r  <= ((rd_idx % 4) == r_err_at) ? 2'b10 : 2'b00;
            end
            if (rvalid_r && axi.rready) begin
                rvalid_r <= 1'b0; rd_idx <= rd_idx + 1;
            end
        end
    end

    // ---------------- checking ----------------
    int n_asserts = 0;
    int n_fail = 0;

    task automatic chk(input string tag, input logic [VW-1:0] got, input logic [VW-1:0] exp);
        n_asserts++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic rand_vec(output logic [VW-1:0] v);
        for (int i = 0; i < 4; i++) v[i*DW +: DW] = $urandom;
    endtask

    task automatic rand_mem();
        for (int i = 0; i < 4; i++) rmem[i] = $urandom;
    endtask

    // Wait for the job handshake; returns 1 once it has happened at the last edge.
    task automatic accept_job(input string name, input logic [VW-1:0] vec);
        bit hs;
        hs = 1'b0;
        job_vec = vec;
        job_valid = 1'b1;
        for (int t = 0; t < 60 && !hs; t++) begin
            hs = job_ready;
            @(posedge aclk); #1;
        end
        chk({name, ".accept"}, hs, 1'b1);
        job_valid = 1'b0;
    endtask

    task automatic run_job(input string name, input logic [VW-1:0] vec, input int hold,
                           input bit push, input bit exp_err, input int exp_lat);
        int wb, rb, lat;
        logic [VW-1:0] exp_vec;
        logic [AW-1:0] ea;
        logic [DW-1:0] ed;
        wb = wr_addr_log.size();
        rb = rd_addr_log.size();
        for (int i = 0; i < 4; i++) exp_vec[i*DW +: DW] = rmem[i];
        accept_job(name, vec);
        lat = 0;
        while (!res_valid && lat < 600) begin
            @(posedge aclk); #1;
            lat++;
        end
        chk({name, ".res_valid"}, res_valid, 1'b1);
        if (exp_lat > 0) chk({name, ".latency"}, lat, exp_lat);
        chk({name, ".nwr"}, wr_addr_log.size() - wb, 5);
        chk({name, ".nrd"}, rd_addr_log.size() - rb, 4);
        for (int k = 0; k < 5; k++) begin
            ea = AW'((k < 4) ? (4 + 4 * k) : 0);
            ed = (k < 4) ? vec[k*DW +: DW] : 32'd1;
            chk($sformatf("%s.wr%0d", name, k), {wr_addr_log[wb+k], wr_data_log[wb+k]}, {ea, ed});
        end
        for (int k = 0; k < 4; k++) begin
            ea = AW'(20 + 4 * k);
            chk($sformatf("%s.rd%0d", name, k), rd_addr_log[rb+k], ea);
        end
        chk({name, ".aw_len"}, aw_len_log[wb], aw_delay + 1);
        chk({name, ".w_len"}, w_len_log[wb], w_delay + 1);
        chk({name, ".res_vec"}, res_vec, exp_vec);
        chk({name, ".res_err"}, res_err, exp_err);
        if (push) begin
            rand_vec(job_vec);
            job_valid = 1'b1;
        end
        for (int c = 0; c < hold; c++) begin
            @(posedge aclk); #1;
            chk($sformatf("%s.hold%0d", name, c), {res_valid, job_ready, busy, res_vec},
                {1'b1, 1'b0, 1'b1, exp_vec});
        end
        res_ready = 1'b1;
        @(posedge aclk); #1;
        res_ready = 1'b0;
        chk({name, ".after"}, {res_valid, job_ready, busy}, {1'b0, 1'b1, 1'b0});
        chk({name, ".viol"}, viol, 0);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        logic [VW-1:0] v;
        int wi0, tr0;
        for (int i = 0; i < 4; i++) rmem[i] = '0;

        // reset
        repeat (3) @(posedge aclk);
        #1;
        chk("reset.outs", {axi.awvalid, axi.wvalid, axi.bready, axi.arvalid, axi.rready,
                           res_valid, res_err, busy}, 8'h00);
        chk("reset.res_vec", res_vec, '0);
        aresetn = 1'b1;
        @(posedge aclk); #1;
        chk("reset.job_ready", job_ready, 1'b1);

        // lanes of 10, known results, zero-wait slave
        for (int i = 0; i < 4; i++) v[i*DW +: DW] = 32'd10;
        rmem[0] = 32'd210; rmem[1] = 32'd240; rmem[2] = -32'sd100; rmem[3] = -32'sd360;
        run_job("basic", v, 0, 1'b0, 1'b0, 5 * 3 + WC + 4 * 2 + 1);

        // random vectors and results, zero-wait
        for (int j = 0; j < 3; j++) begin
            rand_vec(v); rand_mem();
            run_job($sformatf("rnd%0d", j), v, 0, 1'b0, 1'b0, 5 * 3 + WC + 4 * 2 + 1);
        end

        // awready late by 3 cycles, wready immediate
        aw_delay = 3; w_delay = 0;
        rand_vec(v); rand_mem();
        run_job("awstall", v, 0, 1'b0, 1'b0, 0);

        // random stalls on both write channels
        for (int j = 0; j < 2; j++) begin
            aw_delay = $urandom_range(0, 2); w_delay = $urandom_range(0, 3);
            rand_vec(v); rand_mem();
            run_job($sformatf("stall%0d", j), v, 0, 1'b0, 1'b0, 0);
        end
        aw_delay = 0; w_delay = 0;

        // result back-pressure with a new job already pending
        rand_vec(v); rand_mem();
        run_job("hold", v, 5, 1'b1, 1'b0, 0);

        // error responses on second write and third read, then a clean job
        b_err_at = 1; r_err_at = 2;
        rand_vec(v); rand_mem();
        run_job("err", v, 0, 1'b0, 1'b1, 5 * 3 + WC + 4 * 2 + 1);
        b_err_at = -1; r_err_at = -1;
        rand_vec(v); rand_mem();
        run_job("clean", v, 0, 1'b0, 1'b0, 5 * 3 + WC + 4 * 2 + 1);

        // reset while waiting for the core
        rand_vec(v); rand_mem();
        wi0 = wr_idx;
        accept_job("rstjob", v);
        for (int t = 0; t < 100 && wr_idx < wi0 + 5; t++) begin
            @(posedge aclk); #1;
        end
        chk("rst.writes_done", wr_idx - wi0, 5);
        @(posedge aclk); #1;
        chk("rst.in_wait", {busy, axi.awvalid, axi.arvalid}, {1'b1, 1'b0, 1'b0});
        aresetn = 1'b0;
        @(posedge aclk); #1;
        chk("rst.outs", {axi.awvalid, axi.wvalid, axi.bready, axi.arvalid, axi.rready,
                         res_valid, res_err, busy, job_ready}, 9'h001);
        chk("rst.res_vec", res_vec, '0);
        aresetn = 1'b1;
        tr0 = traffic;
        repeat (20) @(posedge aclk);
        #1;
        chk("rst.quiet", traffic - tr0, 0);
        chk("rst.idle", {busy, job_ready}, 2'b01);
        rand_vec(v); rand_mem();
        run_job("postrst", v, 0, 1'b0, 1'b0, 5 * 3 + WC + 4 * 2 + 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
        $finish;
    end
endmodule
